ecg_segment_framer: RTL and testbench
=====================================

Name: ecg_segment_framer

Overview:
- Sits between the FIR filter output stream and the combinational 1-D CNN ECG classifier.
- Collects filtered ECG samples one per handshake into a sliding window of SEG_LEN samples, drives the full window onto the classifier input bus, and waits a fixed settle time.
- Captures the classifier's 8-bit class flag vector and returns it, tagged with a segment number, over a valid/ready result interface.
- Handles both sides of the classifier interface: producing its window input and consuming its flag output.

Parameters:
- SAMPLE_W, 16: sample width, two's-complement.
- SEG_LEN, 32: samples per classified window; must be ≥2.
- HOP, 32: new samples between successive windows after the first; legal range 1..SEG_LEN. HOP<SEG_LEN gives overlapping windows.
- CLS_LAT, 2: cycles the window is held stable before cls_in is sampled; must be ≥1.
- CLS_W, 8: width of the class flag vector.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous, active-high reset.
- s_valid, in, 1: input sample valid.
- s_ready, out, 1: framer can accept a sample.
- s_data, in, SAMPLE_W: filtered ECG sample.
- seg_out, out, SEG_LEN*SAMPLE_W: window to the classifier. Sample i occupies bits [i*SAMPLE_W +: SAMPLE_W]; index 0 is the oldest sample.
- seg_valid, out, 1: seg_out holds a complete, stable window.
- cls_in, in, CLS_W: flag vector from the classifier.
- res_valid, out, 1: result available.
- res_ready, in, 1: downstream accepts the result.
- res_class, out, CLS_W: latched flags (bit0 Normal … bit7 Low R-wave).
- res_seg_id, out, 16: segment number of the result; wraps at 0xFFFF→0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All window registers, counters, res_class and res_seg_id go to 0.
  - s_ready=1 in the cycle after the reset edge; seg_valid=0; res_valid=0.
  - primed=0; state=FILL.
  - Reset wins over every other event at that edge. Reset mid-EVAL or mid-HOLD discards the window and any pending result.
- Sample acceptance: on an edge with s_valid && s_ready.
  - Window shifts toward index 0: buf[i] ← buf[i+1], buf[SEG_LEN-1] ← s_data.
  - new_cnt increments.
  - s_data is stored unmodified; there is no arithmetic on samples.
- FILL state:
  - s_ready=1, seg_valid=0.
  - Target count = SEG_LEN when primed=0, otherwise HOP.
  - On the edge that accepts the sample making new_cnt equal the target: state→EVAL, lat_cnt←0, primed←1, new_cnt←0.
  - Gaps in s_valid simply stall; no timeout.
- EVAL state:
  - s_ready=0, seg_valid=1, seg_out frozen.
  - lat_cnt increments each cycle.
  - On the edge where lat_cnt==CLS_LAT-1: res_class←cls_in, res_valid←1, state→HOLD.
  - Timing: the first sample edge of EVAL is k. res_valid rises after edge k+CLS_LAT and cls_in is sampled at that edge.
- HOLD state:
  - s_ready=0, seg_valid=1, res_valid=1.
  - res_class and res_seg_id are stable until the handshake.
  - On the edge with res_ready: res_valid←0, res_seg_id←res_seg_id+1, state→FILL. s_ready=1 the following cycle.
  - Zero-bubble: if res_ready is already high when res_valid rises, the handshake completes at the next edge.
- Window retention:
  - The window buffer is never cleared except by rst.
  - With HOP<SEG_LEN the next window reuses SEG_LEN-HOP old samples.
  - With HOP=SEG_LEN windows are disjoint.
- Input ordering: no sample is dropped or duplicated. s_ready is registered-state driven; there is no combinational path from s_valid to s_ready.
- seg_valid falls in the same cycle that state returns to FILL.

Test Plan:
- Prime, defaults:
  - Stimulus: rst, then 32 back-to-back samples 10,15,20,18,10,5,0,-5,-10,-8,0,5,10,12,15,20,18,15,12,10,8,5,2,0,-2,-5,-8,-10,-5,0,5,10; res_ready=1.
  - Required: s_ready=0 from the cycle after the 32nd accept; seg_out sample0=0x000A, sample7=0xFFFB, sample31=0x000A; seg_valid=1.
  - Required: cls_in forced to 0x41 → res_valid exactly 2 cycles into EVAL, res_class=0x41, res_seg_id=0.
- Result backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles in HOLD while toggling cls_in.
  - Required: res_class unchanged, s_ready=0, seg_out unchanged; after res_ready=1, one handshake, res_seg_id increments to 1, s_ready=1 next cycle.
- Overlap, HOP=8:
  - Stimulus: prime with samples 1..32, then send 33..40.
  - Required: second window sample0=9, sample31=40; res_seg_id=1; EVAL entered exactly on the 8th new accept.
- Gapped input:
  - Stimulus: s_valid asserted every third cycle for 32 samples.
  - Required: identical seg_out to the back-to-back case; EVAL entered only on the 32nd accept.
- Reset mid-operation:
  - Stimulus: assert rst during EVAL, then again during HOLD.
  - Required: next cycle res_valid=0, seg_valid=0, s_ready=1, seg_out=0, res_seg_id=0; 32 fresh samples are then required before EVAL (primed cleared).
- CLS_LAT=1 and seg_id wrap:
  - Stimulus: CLS_LAT=1, with res_seg_id forced to 0xFFFF via a long run.
  - Required: res_valid one cycle after EVAL entry; the id after 0xFFFF is 0x0000.

Source files
------------

// File: rtl/ecg_segment_framer.sv
// ecg_segment_framer
// Builds a sliding window of filtered ECG samples for the combinational CNN
// classifier, holds it stable for the classifier settle time, then captures the
// class flags and hands them downstream tagged with a running segment number.
module ecg_segment_framer #(
    parameter int SAMPLE_W = 16,
    parameter int SEG_LEN  = 32,
    parameter int HOP      = 32,
    parameter int CLS_LAT  = 2,
    parameter int CLS_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [SAMPLE_W-1:0]          s_data,
    output logic [SEG_LEN*SAMPLE_W-1:0]  seg_out,
    output logic                         seg_valid,
    input  logic [CLS_W-1:0]             cls_in,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [CLS_W-1:0]             res_class,
    output logic [15:0]                  res_seg_id
);

    localparam int CNT_W = $clog2(SEG_LEN + 1);
    localparam int LAT_W = $clog2(CLS_LAT + 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e                             state_q,     state_d;
    logic [SEG_LEN-1:0][SAMPLE_W-1:0]   win_q,       win_d;
    logic [CNT_W-1:0]                   new_cnt_q,   new_cnt_d;
    logic [LAT_W-1:0]                   lat_cnt_q,   lat_cnt_d;
    logic                               primed_q,    primed_d;
    logic                               s_ready_q,   s_ready_d;
    logic                               seg_valid_q, seg_valid_d;
    logic                               res_valid_q, res_valid_d;
    logic [CLS_W-1:0]                   res_class_q, res_class_d;
    logic [15:0]                        res_seg_id_q, res_seg_id_d;

    logic                               accept;
    logic [CNT_W-1:0]                   target;

    // s_ready comes straight from a flop, so accept never loops back into s_ready
    assign accept = s_valid && s_ready_q;
    // the very first window needs a full fill; after that only HOP fresh samples
    assign target = primed_q ? CNT_W'(HOP) : CNT_W'(SEG_LEN);

    // Next-state: window shift on accept, FSM sequencing and registered outputs
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        new_cnt_d    = new_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        primed_d     = primed_q;
        s_ready_d    = s_ready_q;
        seg_valid_d  = seg_valid_q;
        res_valid_d  = res_valid_q;
        res_class_d  = res_class_q;
        res_seg_id_d = res_seg_id_q;

        if (accept) begin
            // oldest sample falls off index 0, newest lands at the top
            for (int i = 0; i < SEG_LEN - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[SEG_LEN-1] = s_data;
            new_cnt_d        = new_cnt_q + CNT_W'(1);
        end

        case (state_q)
            FILL: begin
                if (accept && ((new_cnt_q + CNT_W'(1)) == target)) begin
                    state_d     = EVAL;
                    lat_cnt_d   = '0;
                    primed_d    = 1'b1;
                    new_cnt_d   = '0;
                    s_ready_d   = 1'b0;
                    seg_valid_d = 1'b1;
                end
            end
            EVAL: begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_W'(CLS_LAT - 1)) begin
                    res_class_d = cls_in;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d  = 1'b0;
                    res_seg_id_d = res_seg_id_q + 16'd1;
                    state_d      = FILL;
                    s_ready_d    = 1'b1;
                    seg_valid_d  = 1'b0;
                end
            end
            default: begin
                state_d     = FILL;
                s_ready_d   = 1'b1;
                seg_valid_d = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards the window and any pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            win_q        <= '0;
            new_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            primed_q     <= 1'b0;
            s_ready_q    <= 1'b1;
            seg_valid_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_class_q  <= '0;
            res_seg_id_q <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            new_cnt_q    <= new_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            primed_q     <= primed_d;
            s_ready_q    <= s_ready_d;
            seg_valid_q  <= seg_valid_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            res_seg_id_q <= res_seg_id_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign seg_out    = win_q;
    assign seg_valid  = seg_valid_q;
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_seg_id = res_seg_id_q;

endmodule

// File: tb/tb_ecg_segment_framer.sv
// Directed bench for ecg_segment_framer: three instances cover the default
// configuration, an overlapping HOP=8 window and a single-cycle classifier latency.
module tb_ecg_segment_framer;

    logic         clk;
    logic         rst;
    logic         sv [3];
    logic [15:0]  sd [3];
    logic [7:0]   ci [3];
    logic         rr [3];
    logic         sr [3];
    logic         segv [3];
    logic         rv [3];
    logic [511:0] so [3];
    logic [7:0]   rc [3];
    logic [15:0]  rid [3];

    int vectors = 0;
    int errs    = 0;

    int seq [32] = '{10, 15, 20, 18, 10, 5, 0, -5, -10, -8, 0, 5, 10, 12, 15, 20,
                     18, 15, 12, 10, 8, 5, 2, 0, -2, -5, -8, -10, -5, 0, 5, 10};
    logic [511:0] exp_win;

    ecg_segment_framer dut0 (
        .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
        .seg_out(so[0]), .seg_valid(segv[0]), .cls_in(ci[0]), .res_valid(rv[0]),
        .res_ready(rr[0]), .res_class(rc[0]), .res_seg_id(rid[0]));

    ecg_segment_framer #(.HOP(8)) dut1 (
        .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
        .seg_out(so[1]), .seg_valid(segv[1]), .cls_in(ci[1]), .res_valid(rv[1]),
        .res_ready(rr[1]), .res_class(rc[1]), .res_seg_id(rid[1]));

    ecg_segment_framer #(.CLS_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]),
        .seg_out(so[2]), .seg_valid(segv[2]), .cls_in(ci[2]), .res_valid(rv[2]),
        .res_ready(rr[2]), .res_class(rc[2]), .res_seg_id(rid[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic [15:0] v);
        sv[d] = 1'b1;
        sd[d] = v;
        step();
        sv[d] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] smp(input int d, input int i);
        return so[d][i*16 +: 16];
    endfunction

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sv[d] = 1'b0; sd[d] = '0; ci[d] = '0; rr[d] = 1'b0;
        end
        exp_win = '0;
        for (int i = 0; i < 32; i++) exp_win[i*16 +: 16] = 16'(seq[i]);

        // ---- reset state
        do_reset();
        chk("rst_s_ready",   sr[0],   1);
        chk("rst_seg_valid", segv[0], 0);
        chk("rst_res_valid", rv[0],   0);
        chk("rst_seg_out",   so[0],   0);
        chk("rst_seg_id",    rid[0],  0);
        chk("rst_res_class", rc[0],   0);

        // ---- prime with back-to-back samples
        for (int i = 0; i < 31; i++) send(0, 16'(seq[i]));
        chk("prime_ready_31", sr[0], 1);
        ci[0] = 8'h41;
        send(0, 16'(seq[31]));
        chk("prime_ready_low", sr[0],   0);
        chk("prime_segv",      segv[0], 1);
        chk("prime_rv_e0",     rv[0],   0);
        chk("prime_s0",        smp(0, 0),  16'h000A);
        chk("prime_s7",        smp(0, 7),  16'hFFFB);
        chk("prime_s31",       smp(0, 31), 16'h000A);
        chk("prime_window",    so[0], exp_win);
        step();
        chk("prime_rv_e1",     rv[0], 0);
        step();
        chk("prime_rv_e2",     rv[0], 1);
        chk("prime_class",     rc[0], 8'h41);
        chk("prime_id",        rid[0], 0);

        // ---- result backpressure while the classifier output wanders
        for (int c = 0; c < 10; c++) begin
            ci[0] = 8'(c * 17 + 3);
            step();
            chk("bp_class",  rc[0], 8'h41);
            chk("bp_ready",  sr[0], 0);
            chk("bp_window", so[0], exp_win);
            chk("bp_rv",     rv[0], 1);
        end
        rr[0] = 1'b1;
        step();
        rr[0] = 1'b0;
        chk("bp_rv_drop", rv[0],   0);
        chk("bp_id",      rid[0],  1);
        chk("bp_ready",   sr[0],   1);
        chk("bp_segv",    segv[0], 0);

        // ---- gapped input, zero-bubble result handshake
        do_reset();
        rr[0] = 1'b1;
        ci[0] = 8'h3C;
        for (int i = 0; i < 32; i++) begin
            send(0, 16'(seq[i]));
            if (i == 30) chk("gap_ready_31", sr[0], 1);
            if (i < 31) begin
                step();
                step();
            end
        end
        chk("gap_ready_low", sr[0], 0);
        chk("gap_window",    so[0], exp_win);
        step();
        chk("gap_rv_e1", rv[0], 0);
        step();
        chk("gap_rv_e2", rv[0], 1);
        chk("gap_class", rc[0], 8'h3C);
        chk("gap_id0",   rid[0], 0);
        step();
        chk("gap_zb_rv", rv[0], 0);
        chk("gap_zb_id", rid[0], 1);
        chk("gap_zb_rdy", sr[0], 1);
        rr[0] = 1'b0;

        // ---- reset during EVAL
        for (int i = 0; i < 32; i++) send(0, 16'(seq[i]));
        chk("re_in_eval", segv[0], 1);
        do_reset();
        chk("re_rv",   rv[0],   0);
        chk("re_segv", segv[0], 0);
        chk("re_rdy",  sr[0],   1);
        chk("re_win",  so[0],   0);
        chk("re_id",   rid[0],  0);
        // unprimed again: HOP would be 32 anyway, so count accepts explicitly
        for (int i = 0; i < 31; i++) send(0, 16'(i + 100));
        chk("re_fill_31", sr[0], 1);
        send(0, 16'd131);
        chk("re_fill_32", sr[0], 0);
        step();
        step();
        chk("rh_in_hold", rv[0], 1);
        // ---- reset during HOLD
        do_reset();
        chk("rh_rv",   rv[0],   0);
        chk("rh_segv", segv[0], 0);
        chk("rh_rdy",  sr[0],   1);
        chk("rh_win",  so[0],   0);
        chk("rh_id",   rid[0],  0);

        // ---- overlapping windows, HOP=8
        rr[1] = 1'b1;
        for (int i = 1; i <= 32; i++) send(1, 16'(i));
        chk("ov_first_low", sr[1], 0);
        step();
        step();
        chk("ov_rv", rv[1], 1);
        step();
        chk("ov_hs_id",  rid[1], 1);
        chk("ov_hs_rdy", sr[1],  1);
        for (int i = 33; i <= 39; i++) send(1, 16'(i));
        chk("ov_ready_7", sr[1], 1);
        send(1, 16'd40);
        chk("ov_ready_8", sr[1], 0);
        chk("ov_segv",    segv[1], 1);
        chk("ov_s0",      smp(1, 0),  16'd9);
        chk("ov_s31",     smp(1, 31), 16'd40);
        chk("ov_id",      rid[1], 1);

        // ---- CLS_LAT=1 and segment id wrap
        rr[2] = 1'b1;
        ci[2] = 8'h80;
        force dut2.res_seg_id_q = 16'hFFFF;
        step();
        release dut2.res_seg_id_q;
        step();
        chk("wr_forced_id", rid[2], 16'hFFFF);
        for (int i = 0; i < 32; i++) send(2, 16'(i * 3));
        chk("wr_eval_rv0", rv[2], 0);
        chk("wr_eval_rdy", sr[2], 0);
        step();
        chk("wr_rv1",    rv[2], 1);
        chk("wr_class",  rc[2], 8'h80);
        chk("wr_id_ff",  rid[2], 16'hFFFF);
        step();
        chk("wr_id_wrap", rid[2], 16'h0000);
        chk("wr_rv_drop", rv[2],  0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
